// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - frequency/lock monitor for a divided clock, measured in clk cycles
//
// Purpose:
//   Treats div_clk_i as data: synchronises it into the clk domain, detects its
//   rising edges and measures the period and the synced-high time between
//   consecutive rising edges. Declares lock after LOCK_CNT consecutive periods
//   within EXP_PER +/- TOL, and raises sticky flags for an out-of-tolerance
//   period (err_period) or a clock that has stopped toggling (err_stuck).
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   div_clk_i     divided clock under test (asynchronous data)
//   en            monitor enable; low forces IDLE and drops lock
//   err_clr       one-cycle pulse clearing err_period and err_stuck
//   period_o      last measured period, in clk cycles
//   high_o        synced-high cycles within the last measured period
//   period_valid  one-cycle pulse when period_o / high_o update
//   lock          period stable and in tolerance for LOCK_CNT periods
//   err_period    sticky: a measured period fell outside tolerance
//   err_stuck     sticky: no rising edge for TIMEOUT cycles

module div_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_PER  = 3,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_i,
  input  logic             en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             period_valid,
  output logic             lock,
  output logic             err_period,
  output logic             err_stuck
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]    LOCK_G   = GW'(LOCK_CNT);

  // Tolerance window on the (CNT_W+1)-bit measured period; the low bound is
  // clamped at zero so a wide TOL cannot underflow.
  localparam logic [CNT_W:0] PER_LO = (EXP_PER > TOL) ? (CNT_W+1)'(EXP_PER - TOL) : '0;
  localparam logic [CNT_W:0] PER_HI = (CNT_W+1)'(EXP_PER + TOL);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE
  } state_t;

  state_t          state;
  logic            s1, s2, s3;
  logic            rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [GW-1:0]   good_cnt;

  logic [CNT_W:0]   per_meas;
  logic [CNT_W-1:0] per_sat;
  logic             in_tol;
  logic             timeout;
  logic [GW-1:0]    good_inc;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_clk_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Period and high-time counters. cnt counts clk cycles since the last rise,
  // so the period is cnt+1 at the next rise. hcnt starts at 1 because the
  // rise cycle itself is a synced-high cycle. Both saturate rather than wrap
  // so a stopped clock never aliases into a plausible period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= '0;
      hcnt <= CNT_W'(1);
    end else begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (s2 && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    per_meas = {1'b0, cnt} + (CNT_W+1)'(1);
    per_sat  = (cnt == CNT_MAX) ? CNT_MAX : per_meas[CNT_W-1:0];
    in_tol   = (per_meas >= PER_LO) && (per_meas <= PER_HI);
    // Only consulted when rise is low, so a rise in the timeout cycle wins.
    timeout  = (cnt == TO_LAST);
    good_inc = (good_cnt == LOCK_G) ? good_cnt : good_cnt + GW'(1);
  end

  // Control FSM with registered outputs. err_clr is applied first so that an
  // error detected in the same cycle overrides it and the flag stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      period_o     <= '0;
      high_o       <= '0;
      period_valid <= 1'b0;
      lock         <= 1'b0;
      err_period   <= 1'b0;
      err_stuck    <= 1'b0;
      good_cnt     <= '0;
    end else begin
      period_valid <= 1'b0;

      if (err_clr) begin
        err_period <= 1'b0;
        err_stuck  <= 1'b0;
      end

      if (!en) begin
        state    <= IDLE;
        lock     <= 1'b0;
        good_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQUIRE;
          end

          // The first rise only aligns the measurement; the partial period
          // before it is meaningless and is not reported.
          ACQUIRE: begin
            if (rise) begin
              state <= MEASURE;
            end else if (timeout) begin
              err_stuck <= 1'b1;
              lock      <= 1'b0;
              good_cnt  <= '0;
              state     <= ACQUIRE;
            end
          end

          MEASURE: begin
            if (rise) begin
              period_o     <= per_sat;
              high_o       <= hcnt;
              period_valid <= 1'b1;
              if (in_tol) begin
                good_cnt <= good_inc;
                lock     <= (good_inc == LOCK_G);
              end else begin
                good_cnt   <= '0;
                lock       <= 1'b0;
                err_period <= 1'b1;
              end
            end else if (timeout) begin
              err_stuck <= 1'b1;
              lock      <= 1'b0;
              good_cnt  <= '0;
              state     <= ACQUIRE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
